// File: rtl/acl2_pkg.sv
// Shared ADXL362 constants and sampler state encoding for the PmodACL2 blocks.
// Pure declarations: no logic, no latency, no flow control.
package acl2_pkg;

  localparam logic [7:0] ADXL_CMD_WRITE = 8'h0A;
  localparam logic [7:0] ADXL_CMD_READ  = 8'h0B;

  localparam logic [7:0] ADXL_XDATA_L = 8'h0E;
  localparam logic [7:0] ADXL_XDATA_H = 8'h0F;
  localparam logic [7:0] ADXL_YDATA_L = 8'h10;
  localparam logic [7:0] ADXL_YDATA_H = 8'h11;
  localparam logic [7:0] ADXL_ZDATA_L = 8'h12;
  localparam logic [7:0] ADXL_ZDATA_H = 8'h13;

  localparam int unsigned NUM_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  // The H register repeats the sign in its upper nibble; only bits [3:0] carry data.
  function automatic logic [11:0] join12(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[3:0], lo};
  endfunction

endpackage

// File: rtl/acl2_sampler_period_timer.sv
// Burst-start timer: free-running 0..PERIOD-1 counter while enabled, tick on wrap or enable rise.
// Tick is combinational from the count and enable; no backpressure, a tick is a single-cycle pulse.
module period_timer #(
  parameter int unsigned PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(PERIOD - 1));
    en_d  = enable;
    cnt_d = cnt_q;
    if (!enable || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // A fresh enable fires immediately so the first burst does not wait a full period.
    tick = enable && (!en_q || wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

endmodule

// File: rtl/acl2_sampler.sv
// Periodic ADXL362 X/Y/Z reader over a 24-bit SPI handshake; publishes 12-bit triples with a strobe.
// Six single-register reads per burst; spi_send waits on spi_ready, excess period ticks set sticky overrun.
module acl2_sampler
  import acl2_pkg::*;
#(
  parameter int unsigned PERIOD    = 100000,
  parameter logic [7:0]  CMD_READ  = ADXL_CMD_READ,
  parameter logic [7:0]  BASE_ADDR = ADXL_XDATA_L
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        enable,
  input  logic        spi_ready,
  output logic        spi_send,
  output logic [23:0] spi_tx,
  input  logic        spi_arrived,
  input  logic [23:0] spi_rx,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [11:0] z,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][7:0] byte_q, byte_d;
  logic [11:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic            sample_valid_q, sample_valid_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            tick;
  logic            leaving_idle;
  logic [7:0]      rd_addr;
  logic [23:0]     frame;
  logic            unused_rx_hi;

  assign unused_rx_hi = ^spi_rx[23:8];

  period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk   (Clock),
    .rst   (Reset),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    rd_addr = BASE_ADDR + 8'(idx_q);
    frame   = {CMD_READ, rd_addr, 8'h00};
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    byte_d         = byte_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    sample_valid_d = 1'b0;
    spi_send       = 1'b0;
    spi_tx         = 24'h0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q && enable) begin
          state_d = ST_ISSUE;
          idx_d   = 3'd0;
        end
      end

      ST_ISSUE: begin
        spi_tx   = frame;
        spi_send = spi_ready;
        if (spi_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        spi_tx = frame;
        if (spi_arrived) begin
          byte_d[idx_q] = spi_rx[7:0];
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_PUBLISH;
          end
        end
      end

      ST_PUBLISH: begin
        // Outputs move only here so a consumer never sees a mix of two bursts.
        x_d            = join12(byte_q[1], byte_q[0]);
        y_d            = join12(byte_q[3], byte_q[2]);
        z_d            = join12(byte_q[5], byte_q[4]);
        sample_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    leaving_idle = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    pending_d    = pending_q;
    overrun_d    = overrun_q;

    if (tick && (pending_q || busy)) begin
      overrun_d = 1'b1;
    end

    // At most one burst is remembered; extra ticks are dropped and only flagged.
    if (!enable || leaving_idle) begin
      pending_d = 1'b0;
    end else if (tick && !busy) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= 3'd0;
      byte_q         <= '0;
      x_q            <= 12'h0;
      y_q            <= 12'h0;
      z_q            <= 12'h0;
      sample_valid_q <= 1'b0;
      pending_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      byte_q         <= byte_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      sample_valid_q <= sample_valid_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign z            = z_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_acl2_sampler.sv
// Directed-plus-random bench for acl2_sampler: behavioural SPI slave, triple scoreboard, sticky-flag checks.
module tb_acl2_sampler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b0;
  logic        spi_ready = 1'b1;
  logic        spi_send;
  logic [23:0] spi_tx;
  logic        spi_arrived = 1'b0;
  logic [23:0] spi_rx = 24'h0;
  logic [11:0] x, y, z;
  logic        sample_valid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  acl2_sampler #(
    .PERIOD   (64),
    .CMD_READ (8'h0B),
    .BASE_ADDR(8'h0E)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .enable      (enable),
    .spi_ready   (spi_ready),
    .spi_send    (spi_send),
    .spi_tx      (spi_tx),
    .spi_arrived (spi_arrived),
    .spi_rx      (spi_rx),
    .x           (x),
    .y           (y),
    .z           (z),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 Clock = ~Clock;

  // SPI slave model and scoreboard state.
  int          lat = 3;
  int          hold_req = 0;
  int          block = 0;
  int          remaining = 0;
  bit          accepted = 0;
  int          sends_in_burst = 0;
  int          sends_total = 0;
  int          pubs = 0;
  bit          busy_seen = 0;
  bit          prev_sv = 0;
  logic [35:0] prev_xyz = '0;
  byte unsigned fixed_q[$];
  int          burst_bytes[$];
  logic [35:0] exp_q[$];
  logic [23:0] tx_log[$];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      spi_arrived = 1'b0;
      if (Reset) begin
        spi_ready = 1'b1;
        accepted = 0; remaining = 0; block = 0;
        sends_in_burst = 0;
        burst_bytes.delete();
        exp_q.delete();
        prev_xyz = '0;
        prev_sv = 0;
        continue;
      end
      if (accepted) begin
        accepted = 0;
        remaining = lat;
        spi_ready = 1'b0;
      end else if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          int b;
          logic [31:0] noise;
          b = (fixed_q.size() > 0) ? int'(fixed_q.pop_front()) : int'($urandom_range(0, 255));
          noise = $urandom;
          spi_rx = {noise[15:0], 8'(b)};
          spi_arrived = 1'b1;
          burst_bytes.push_back(b);
          if (burst_bytes.size() == 6) begin
            int ex, ey, ez;
            ex = ((burst_bytes[1] % 16) * 256) + burst_bytes[0];
            ey = ((burst_bytes[3] % 16) * 256) + burst_bytes[2];
            ez = ((burst_bytes[5] % 16) * 256) + burst_bytes[4];
            exp_q.push_back({12'(ex), 12'(ey), 12'(ez)});
            burst_bytes.delete();
          end
          if (hold_req > 0 && sends_in_burst == 2) begin
            block = hold_req;
            hold_req = 0;
            spi_ready = 1'b0;
          end else begin
            spi_ready = 1'b1;
          end
        end
      end else if (block > 0) begin
        chk("busy_in_hold", {35'h0, busy}, 36'h1);
        block--;
        if (block == 0) spi_ready = 1'b1;
      end
      #1;
      if (busy) busy_seen = 1;
      if (spi_send) begin
        chk("send_needs_ready", {35'h0, spi_ready}, 36'h1);
        chk("tx_frame", {12'h0, spi_tx}, {12'h0, 8'h0B, 8'(14 + sends_in_burst), 8'h00});
        sends_in_burst++;
        sends_total++;
        tx_log.push_back(spi_tx);
        accepted = 1;
      end
      if (sample_valid) begin
        logic [35:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("xyz_triple", {x, y, z}, e);
        chk("sends_per_burst", 36'(sends_in_burst), 36'd6);
        chk("sv_width", {35'h0, prev_sv}, 36'h0);
        sends_in_burst = 0;
        pubs++;
      end else begin
        chk("xyz_hold", {x, y, z}, prev_xyz);
      end
      prev_xyz = {x, y, z};
      prev_sv = sample_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_pubs(input int target, input int budget, input string tag);
    int n = 0;
    while (pubs < target && n < budget) begin
      @(posedge Clock);
      n++;
    end
    #1;
    chk(tag, 36'(pubs >= target), 36'h1);
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int n = 0;
    while (sends_in_burst < target && n < budget) begin
      @(posedge Clock);
      n++;
    end
    #1;
    chk(tag, 36'(sends_in_burst >= target), 36'h1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge Clock);
      n++;
    end
    #1;
    chk(tag, {35'h0, busy}, 36'h0);
  endtask

  initial begin
    int p0, s0, log0;

    // Reset, then a long disabled stretch.
    Reset = 1'b1; enable = 1'b0;
    cycles(3);
    chk("rst_xyz", {x, y, z}, 36'h0);
    chk("rst_flags", {32'h0, sample_valid, busy, overrun, spi_send}, 36'h0);
    chk("rst_tx", {12'h0, spi_tx}, 36'h0);
    Reset = 1'b0;
    cycles(50);
    chk("idle_sends", 36'(sends_total), 36'd0);
    chk("idle_busy", {35'h0, busy_seen}, 36'h0);
    chk("idle_xyz", {x, y, z}, 36'h0);
    chk("idle_pubs", 36'(pubs), 36'd0);

    // Known bytes: sign nibbles of the H bytes must be dropped.
    fixed_q = '{8'h34, 8'hF2, 8'h78, 8'h05, 8'hBC, 8'h0A};
    lat = 3;
    log0 = tx_log.size();
    enable = 1'b1;
    wait_pubs(1, 300, "first_burst_timeout");
    enable = 1'b0;
    chk("first_x", 36'(x), 36'h234);
    chk("first_y", 36'(y), 36'h578);
    chk("first_z", 36'(z), 36'hABC);
    chk("first_log_len", 36'(tx_log.size() - log0), 36'd6);
    if (tx_log.size() >= log0 + 6) begin
      chk("first_addr0", {12'h0, tx_log[log0]}, 36'h0B0E00);
      chk("first_addr5", {12'h0, tx_log[log0 + 5]}, 36'h0B1300);
    end
    cycles(20);
    chk("one_pulse", 36'(pubs), 36'd1);
    chk("no_overrun_short", {35'h0, overrun}, 36'h0);

    // spi_ready held low while the FSM sits in ISSUE.
    hold_req = 10;
    s0 = sends_total;
    enable = 1'b1;
    wait_pubs(2, 400, "hold_burst_timeout");
    enable = 1'b0;
    chk("hold_sends", 36'(sends_total - s0), 36'd6);
    chk("hold_consumed", 36'(hold_req), 36'd0);
    cycles(20);
    chk("no_overrun_hold", {35'h0, overrun}, 36'h0);

    // Transfers far longer than the period: overrun latches and stays.
    lat = 40;
    enable = 1'b1;
    wait_pubs(4, 2000, "slow_burst_timeout");
    chk("overrun_set", {35'h0, overrun}, 36'h1);
    wait_pubs(5, 1000, "slow_burst3_timeout");
    chk("overrun_sticky", {35'h0, overrun}, 36'h1);
    enable = 1'b0;
    wait_idle(600, "slow_drain_timeout");
    cycles(5);

    // enable falls during the third transfer: burst completes, then silence.
    lat = 5;
    p0 = pubs;
    enable = 1'b1;
    wait_sends(3, 300, "third_xfer_timeout");
    enable = 1'b0;
    wait_pubs(p0 + 1, 300, "drop_burst_timeout");
    s0 = sends_total;
    cycles(200);
    chk("drop_no_sends", 36'(sends_total - s0), 36'd0);
    chk("drop_one_pulse", 36'(pubs - p0), 36'd1);
    chk("drop_idle", {35'h0, busy}, 36'h0);

    // Reset in the fourth transfer, released with enable still high.
    lat = 4;
    p0 = pubs;
    enable = 1'b1;
    wait_sends(4, 300, "fourth_xfer_timeout");
    Reset = 1'b1;
    cycles(2);
    chk("mid_rst_xyz", {x, y, z}, 36'h0);
    chk("mid_rst_flags", {32'h0, sample_valid, busy, overrun, spi_send}, 36'h0);
    chk("mid_rst_pubs", 36'(pubs - p0), 36'd0);
    log0 = tx_log.size();
    Reset = 1'b0;
    wait_pubs(p0 + 1, 300, "post_rst_timeout");
    chk("post_rst_log_len", 36'(tx_log.size() - log0), 36'd6);
    if (tx_log.size() > log0)
      chk("post_rst_addr0", {12'h0, tx_log[log0]}, 36'h0B0E00);
    enable = 1'b0;
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
